// File: rtl/seq_det_event_log_pkg.sv
// Shared definitions for the sequence-detector event logger: event type
// encodings, default record geometry and a small record-building helper.
package seq_det_pkg;

    // Record type is simply {det_b, det_a}, so "both" falls out naturally.
    typedef enum logic [1:0] {
        EV_NONE  = 2'b00,
        EV_10101 = 2'b01,
        EV_10001 = 2'b10,
        EV_BOTH  = 2'b11
    } ev_type_e;

    localparam int TS_W_DEFAULT = 12;
    localparam int EV_W         = 2 + TS_W_DEFAULT;

    // Map the two detect pulses onto the record type field.
    function automatic ev_type_e ev_type_of(input logic detA, input logic detB);
        return ev_type_e'({detB, detA});
    endfunction

endpackage

// File: rtl/seq_det_event_log_if.sv
// Valid/ready event stream carrying one logged detection record per beat.
// The logger drives the master side; the host or monitor is the slave.
interface seq_det_event_log_if #(
    parameter int TS_W = 12
);
    logic            ev_valid;
    logic            ev_ready;
    logic [1:0]      ev_type;
    logic [TS_W-1:0] ev_time;

    modport master (
        output ev_valid,
        output ev_type,
        output ev_time,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_type,
        input  ev_time,
        output ev_ready
    );
endinterface

// File: rtl/seq_det_event_log_event_fifo.sv
// Small synchronous FIFO for event records. The head entry is read straight
// out of the storage flops, so the outputs never depend combinationally on
// pop. A push into a full FIFO is accepted only if a pop frees a slot on the
// same edge; flush empties the FIFO and wins over push and pop.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign dout_o  = mem_q[rdPtr_q];

    // Occupancy only moves when exactly one of push/pop is accepted.
    always_comb begin
        count_d = count_q;
        unique case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Record storage; zeroed on reset so the head reads as all-zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

endmodule

// File: rtl/seq_det_event_log.sv
// Event logger sitting behind the 10101 / 10001 detector pair. Counts each
// pattern with a saturating counter and logs every detecting edge as a
// timestamped record into a FIFO that the host drains over valid/ready.
// A synchronous clear zeroes the counters, flushes the FIFO and drops the
// overflow flag; it overrides any detect or pop on the same edge.
module seq_det_event_log
    import seq_det_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TS_W  = 12,
    parameter int CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 det_a,
    input  logic                 det_b,
    input  logic                 clear,
    seq_det_event_log_if.master  ev,
    output logic [CNT_W-1:0]     cnt_a,
    output logic [CNT_W-1:0]     cnt_b,
    output logic                 overflow
);

    localparam int EvW = 2 + TS_W;

    logic [TS_W-1:0]  timer_q;
    logic [CNT_W-1:0] cntA_q;
    logic [CNT_W-1:0] cntA_d;
    logic [CNT_W-1:0] cntB_q;
    logic [CNT_W-1:0] cntB_d;
    logic             overflow_q;
    logic             overflow_d;

    ev_type_e         recType;
    logic [EvW-1:0]   recData;
    logic [EvW-1:0]   fifoDout;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             pushReq;
    logic             popReq;
    logic             dropRec;

    // A record is stamped with the timer value seen at the detecting edge.
    assign recType = ev_type_of(det_a, det_b);
    assign recData = {recType, timer_q};

    assign pushReq = (det_a || det_b) && !clear;
    assign popReq  = !fifoEmpty && ev.ev_ready;
    assign dropRec = pushReq && fifoFull && !popReq;

    // Free-running timestamp; clear deliberately leaves it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Next-state for the saturating counters and the sticky overflow flag.
    always_comb begin
        cntA_d     = cntA_q;
        cntB_d     = cntB_q;
        overflow_d = overflow_q;
        if (clear) begin
            cntA_d     = '0;
            cntB_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (det_a && (cntA_q != '1)) begin
                cntA_d = cntA_q + 1'b1;
            end
            if (det_b && (cntB_q != '1)) begin
                cntB_d = cntB_q + 1'b1;
            end
            if (dropRec) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cntA_q     <= '0;
            cntB_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            cntA_q     <= cntA_d;
            cntB_q     <= cntB_d;
            overflow_q <= overflow_d;
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EvW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (clear),
        .push_i  (pushReq),
        .din_i   (recData),
        .pop_i   (popReq),
        .dout_o  (fifoDout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign ev.ev_valid = !fifoEmpty;
    assign ev.ev_type  = fifoDout[EvW-1 -: 2];
    assign ev.ev_time  = fifoDout[TS_W-1:0];

    assign cnt_a    = cntA_q;
    assign cnt_b    = cntB_q;
    assign overflow = overflow_q;

endmodule

// File: doc/seq_det_event_log.md
# seq_det_event_log

Downstream consumer of the two 5-bit sequence detectors (10101 and 10001). It samples both single-cycle detect pulses and keeps a saturating occurrence count per pattern. Each detection is also logged as a timestamped event record in a small FIFO, which a host or monitor drains over a valid/ready handshake. It sits between the detector pair and the host or monitoring logic.

## Interface
- `DEPTH`, 4: event FIFO entries; power of two, ≥2.
- `TS_W`, 12: timestamp width in bits.
- `CNT_W`, 8: per-pattern occurrence counter width.

- `clock`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `det_a`  in  1  detect pulse from the 10101 detector.
- `det_b`  in  1  detect pulse from the 10001 detector.
- `clear`  in  1  synchronous clear: zeroes counters, flushes the FIFO, clears `overflow`.
- `ev_valid`  out  1  FIFO head holds a valid record.
- `ev_ready`  in  1  consumer accepts the head.
- `ev_type`  out  2  head record type: 01 = 10101, 10 = 10001, 11 = both.
- `ev_time`  out  TS_W  head record timestamp.
- `cnt_a`  out  CNT_W  saturating count of `det_a` events.
- `cnt_b`  out  CNT_W  saturating count of `det_b` events.
- `overflow`  out  1  sticky flag: at least one record was dropped because the FIFO was full.

## Operation
- `det_a` and `det_b` come from Mealy detectors, so they are combinational. They are sampled only at the rising edge.
- Free-running timer, TS_W bits:
  - It is 0 in the first cycle after reset is released and increments every cycle.
  - It wraps from 2^TS_W−1 to 0.
  - `clear` does not affect it.
- Event capture: if `det_a` or `det_b` is 1 at edge E, one record {type = {det_b, det_a}, time = timer value before E} is pushed. Two simultaneous detects produce one record of type 11, not two.
- Counters:
  - `cnt_a` increments on each sampled `det_a`; `cnt_b` on each sampled `det_b`.
  - Both saturate at 2^CNT_W−1 and never wrap.
  - Counting is independent of FIFO state.
- FIFO:
  - A pop happens on any edge where `ev_valid` and `ev_ready` are both 1.
  - Push when full with no pop: the record is dropped, `overflow` is set, counters still update.
  - Push when full with a pop on the same edge: the push is accepted and occupancy stays at DEPTH.
  - Push when empty: the record is visible on `ev_valid` in the next cycle.
  - Simultaneous push and pop at any occupancy: occupancy is unchanged and order is preserved.
- `clear` has priority over everything in the same cycle:
  - Any detect on that edge is neither counted nor logged.
  - Any pop on that edge is discarded along with the rest of the FIFO.
- `ev_type` and `ev_time` are don't-care while `ev_valid` = 0. They must hold stable while `ev_valid` = 1 and `ev_ready` = 0.

## Timing
- Reset values: `ev_valid` = 0, `ev_type` = 0, `ev_time` = 0, `cnt_a` = 0, `cnt_b` = 0, `overflow` = 0. The timer and FIFO pointers are 0.
- Reset asserted mid-operation clears all state asynchronously, including the FIFO and any pending handshake.
- Latency from detect edge to `ev_valid` high is 1 cycle when the FIFO is empty.
- Counter outputs are registered and show the new value 1 cycle after the detect edge.
- There is no combinational path from `ev_ready` to `ev_valid` or to the data outputs.
- Throughput is one push and one pop per cycle.

## Structure
- Shared package `seq_det_pkg` holds:
  - event type constants `EV_NONE` = 2'b00, `EV_10101` = 2'b01, `EV_10001` = 2'b10, `EV_BOTH` = 2'b11;
  - the record width `EV_W` = 2 + TS_W.
- Sub-module `event_fifo`: synchronous FIFO with registered output, DEPTH × EV_W, push/pop/full/empty, and synchronous flush.
- The top level contains the timer, the two saturating counters, push/overflow logic and the `clear` priority.

## Test plan
- Reset, then a `det_a` pulse at timer = 5 with `ev_ready` = 1 → next cycle `ev_valid` = 1, `ev_type` = 01, `ev_time` = 5; `cnt_a` = 1.
- `det_a` and `det_b` high on the same edge → exactly one record with `ev_type` = 11; `cnt_a` and `cnt_b` each increment by 1.
- `ev_ready` = 0 and 5 `det_b` pulses, DEPTH = 4 → 4 records retained with ascending timestamps; `overflow` = 1; `cnt_b` = 5. Drain → 4 records in order, then `ev_valid` = 0.
- FIFO full, with a `det_a` pulse and a pop on the same edge → push accepted, `overflow` stays 0, occupancy stays 4, new record appears last.
- 300 `det_a` pulses with CNT_W = 8 → `cnt_a` = 255 and holds. Then `clear` together with a `det_a` pulse → `cnt_a` = 0, FIFO empty, `overflow` = 0, no record logged.
- Reset asserted while `ev_valid` = 1 mid-drain → all outputs 0 immediately. After release, the timer restarts at 0.
